// File: rtl/hazard_stall_ctrl.sv
// Purpose: pipeline freeze generation for load-use hazards and HI/LO (mult/div) occupancy.
// Latency: stall/stallstall are combinational in the same cycle; busy is registered (loads on the issuing edge).
// Backpressure: stall or stallstall freezes PC and IF/ID; a bubble is pushed into the EX shadow while frozen.
//
// Ports:
//   Clk, Reset          clock (rising edge), asynchronous active-low reset
//   id_rs, id_rt        source register fields of the ID instruction
//   id_use_rs/id_use_rt ID instruction actually reads rs / rt
//   id_is_load          ID instruction is a load
//   id_dst              ID destination register (0 = none)
//   id_md_start         ID instruction is mult/multu/div/divu
//   id_md_is_div        with id_md_start: 1 = divide, 0 = multiply
//   id_md_use           ID instruction needs the HI/LO unit
//   stall               load-use freeze
//   stallstall          mult/div busy freeze
//   busy                remaining mult/div cycles, 0 = idle
module hazard_stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_load,
    input  logic [4:0] id_dst,
    input  logic       id_md_start,
    input  logic       id_md_is_div,
    input  logic       id_md_use,
    output logic       stall,
    output logic       stallstall,
    output logic [3:0] busy
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    // Shadow of the ID/EX stage: only what is needed to spot a load-use hazard.
    logic       ex_load_q;
    logic [4:0] ex_dst_q;
    logic [3:0] cnt;

    logic rs_hit;
    logic rt_hit;
    logic advance;

    assign rs_hit = id_use_rs && (id_rs == ex_dst_q);
    assign rt_hit = id_use_rt && (id_rt == ex_dst_q);

    // A load to $0 never produces a value anyone waits for.
    assign stall      = ex_load_q && (ex_dst_q != 5'd0) && (rs_hit || rt_hit);
    // Any HI/LO-class instruction (including a new start) waits for the unit to drain.
    assign stallstall = id_md_use && (cnt != 4'd0);
    assign advance    = !stall && !stallstall;
    assign busy       = cnt;

    // While frozen the ID instruction stays put and a bubble enters EX, so a
    // load-use stall clears itself after exactly one cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ex_load_q <= 1'b0;
            ex_dst_q  <= 5'd0;
        end else if (advance) begin
            ex_load_q <= id_is_load;
            ex_dst_q  <= id_dst;
        end else begin
            ex_load_q <= 1'b0;
            ex_dst_q  <= 5'd0;
        end
    end

    // A start can only advance with cnt == 0 (it also asserts id_md_use), so a
    // load never overwrites a live count. The count keeps draining during
    // load-use stalls.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt <= 4'd0;
        end else if (advance && id_md_start) begin
            cnt <= id_md_is_div ? DIV_CNT : MULT_CNT;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    logic       Clk;
    logic       Reset;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_is_load;
    logic [4:0] id_dst;
    logic       id_md_start;
    logic       id_md_is_div;
    logic       id_md_use;
    logic       stall;
    logic       stallstall;
    logic [3:0] busy;

    hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_is_load  (id_is_load),
        .id_dst      (id_dst),
        .id_md_start (id_md_start),
        .id_md_is_div(id_md_is_div),
        .id_md_use   (id_md_use),
        .stall       (stall),
        .stallstall  (stallstall),
        .busy        (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       is_load;
        logic [4:0] dst;
        logic       md_start;
        logic       md_is_div;
        logic       md_use;
        logic       exp_stall;
        logic       exp_ss;
        logic [3:0] exp_busy;
    } vec_t;

    vec_t tbl [0:63];
    int   n_vec;
    int   checks;
    int   failures;

    function automatic vec_t alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                                 input logic urs, input logic urt);
        vec_t v;
        v.rs = rs; v.rt = rt; v.use_rs = urs; v.use_rt = urt; v.is_load = 1'b0; v.dst = dst;
        v.md_start = 1'b0; v.md_is_div = 1'b0; v.md_use = 1'b0;
        v.exp_stall = 1'b0; v.exp_ss = 1'b0; v.exp_busy = 4'd0;
        return v;
    endfunction

    function automatic vec_t nop();
        return alu(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t lw(input logic [4:0] dst, input logic [4:0] base);
        vec_t v;
        v = alu(base, 5'd0, dst, 1'b1, 1'b0);
        v.is_load = 1'b1;
        return v;
    endfunction

    function automatic vec_t md(input logic is_div, input logic [4:0] rs, input logic [4:0] rt);
        vec_t v;
        v = alu(rs, rt, 5'd0, 1'b1, 1'b1);
        v.md_start = 1'b1; v.md_is_div = is_div; v.md_use = 1'b1;
        return v;
    endfunction

    function automatic vec_t mfhi(input logic [4:0] dst);
        vec_t v;
        v = alu(5'd0, 5'd0, dst, 1'b0, 1'b0);
        v.md_use = 1'b1;
        return v;
    endfunction

    function automatic vec_t expect_v(input vec_t vi, input logic es, input logic ess, input logic [3:0] eb);
        vec_t v;
        v = vi;
        v.exp_stall = es; v.exp_ss = ess; v.exp_busy = eb;
        return v;
    endfunction

    task automatic add(input vec_t v, input logic es, input logic ess, input logic [3:0] eb);
        tbl[n_vec] = expect_v(v, es, ess, eb);
        n_vec++;
    endtask

    task automatic check_out(input string tag, input logic es, input logic ess, input logic [3:0] eb);
        checks++;
        if (stall !== es || stallstall !== ess || busy !== eb) begin
            failures++;
            $display("FAIL %s: got stall=%b stallstall=%b busy=%0d, want stall=%b stallstall=%b busy=%0d",
                     tag, stall, stallstall, busy, es, ess, eb);
        end
    endtask

    // Present one ID instruction for one cycle and check the same-cycle outputs.
    task automatic step(input string tag, input vec_t v);
        @(posedge Clk);
        #1;
        id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
        id_is_load = v.is_load; id_dst = v.dst; id_md_start = v.md_start;
        id_md_is_div = v.md_is_div; id_md_use = v.md_use;
        @(negedge Clk);
        check_out(tag, v.exp_stall, v.exp_ss, v.exp_busy);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t add_rs8;
        vec_t sub_rt8;
        vec_t mul9;
        checks = 0; failures = 0; n_vec = 0;

        // ---------------- vector table ----------------
        add_rs8 = alu(5'd8, 5'd3, 5'd10, 1'b1, 1'b1);
        sub_rt8 = alu(5'd4, 5'd8, 5'd11, 1'b1, 1'b1);
        add(lw(5'd8, 5'd29), 0, 0, 0);
        add(add_rs8,           1, 0, 0);   // load-use via rs
        add(add_rs8,           0, 0, 0);   // bubble cleared it
        add(lw(5'd8, 5'd29), 0, 0, 0);
        add(sub_rt8,           1, 0, 0);   // load-use via rt
        add(sub_rt8,           0, 0, 0);
        add(lw(5'd8, 5'd29), 0, 0, 0);
        add(alu(5'd8, 5'd5, 5'd12, 1'b0, 1'b1), 0, 0, 0); // rs matches but unused
        add(lw(5'd0, 5'd29), 0, 0, 0);
        add(alu(5'd0, 5'd0, 5'd13, 1'b1, 1'b1), 0, 0, 0); // reader of $0 after lw $0
        // mult then mfhi: held for exactly 5 cycles
        add(md(1'b0, 5'd2, 5'd3), 0, 0, 0);
        for (int b = 5; b >= 1; b--) add(mfhi(5'd14), 0, 1, 4'(b));
        add(mfhi(5'd14), 0, 0, 0);
        // div followed by independent ALU ops: full countdown, never held
        add(md(1'b1, 5'd2, 5'd3), 0, 0, 0);
        for (int b = 10; b >= 0; b--) add(alu(5'd1, 5'd2, 5'd15, 1'b1, 1'b1), 0, 0, 4'(b));
        // div again, then a mult arrives while busy = 3
        add(md(1'b1, 5'd2, 5'd3), 0, 0, 0);
        for (int b = 10; b >= 4; b--) add(nop(), 0, 0, 4'(b));
        for (int b = 3; b >= 1; b--) add(md(1'b0, 5'd2, 5'd3), 0, 1, 4'(b));
        add(md(1'b0, 5'd2, 5'd3), 0, 0, 0);
        add(nop(), 0, 0, 5);
        add(nop(), 0, 0, 4);

        // ---------------- reset state ----------------
        Reset = 1'b0;
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_is_load = 0; id_dst = 0;
        id_md_start = 0; id_md_is_div = 0; id_md_use = 0;
        #12;
        check_out("reset_held", 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check_out("reset_release", 0, 0, 0);

        // ---------------- table ----------------
        for (int i = 0; i < n_vec; i++) step($sformatf("vec%0d", i), tbl[i]);

        // ---------------- combined hazard ----------------
        for (int b = 3; b >= 1; b--) step("drain", expect_v(nop(), 0, 0, 4'(b)));
        step("lw9", expect_v(lw(5'd9, 5'd29), 0, 0, 0));
        mul9 = md(1'b0, 5'd9, 5'd3);
        step("mult_blocked", expect_v(mul9, 1, 0, 0));
        step("mult_retry", expect_v(mul9, 0, 0, 0));
        checks++;
        if (dut.ex_load_q !== 1'b0) begin
            failures++;
            $display("FAIL bubble_ex_load: got %b want 0", dut.ex_load_q);
        end
        step("mult_loaded", expect_v(nop(), 0, 0, 5));

        // count keeps draining through a load-use stall
        step("lw7", expect_v(lw(5'd7, 5'd29), 0, 0, 4));
        step("use7", expect_v(alu(5'd7, 5'd0, 5'd16, 1'b1, 1'b0), 1, 0, 3));
        step("use7_go", expect_v(alu(5'd7, 5'd0, 5'd16, 1'b1, 1'b0), 0, 0, 2));
        step("drain1", expect_v(nop(), 0, 0, 1));

        // ---------------- reset mid-operation ----------------
        step("div2", expect_v(md(1'b1, 5'd2, 5'd3), 0, 0, 0));
        step("div_b10", expect_v(nop(), 0, 0, 10));
        step("div_b9", expect_v(nop(), 0, 0, 9));
        step("lw6", expect_v(lw(5'd6, 5'd29), 0, 0, 8));
        begin
            vec_t mthi6;
            mthi6 = alu(5'd6, 5'd0, 5'd0, 1'b1, 1'b0);
            mthi6.md_use = 1'b1;
            step("both_flags", expect_v(mthi6, 1, 1, 7));
        end
        #2;
        Reset = 1'b0;
        #1;
        check_out("async_reset", 0, 0, 0);
        @(negedge Clk);
        check_out("reset_over_edge", 0, 0, 0);
        Reset = 1'b1;
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Generates the pipeline freeze signals `stall` and `stallstall` consumed by the PC and the IF/ID register.
- Generates the 4-bit multiply/divide `busy` countdown consumed by the PC.
- Keeps its own shadow of the ID/EX stage (load flag and destination) so it can detect load-use hazards.
- Tracks the occupancy of the multi-cycle mult/div unit and holds back any HI/LO-class instruction until that unit is idle.

Parameters:
- MULT_CYCLES, 5: busy count loaded when a mult/multu issues; legal range 1..15.
- DIV_CYCLES, 10: busy count loaded when a div/divu issues; legal range 1..15.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_is_load  in  1  ID instruction is lw/lh/lb-class.
- id_dst  in  5  destination register of the ID instruction; 0 means none.
- id_md_start  in  1  ID instruction is mult/multu/div/divu.
- id_md_is_div  in  1  with id_md_start: 1 = div, 0 = mult.
- id_md_use  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo (needs the HI/LO unit).
- stall  out  1  load-use freeze.
- stallstall  out  1  mult/div busy freeze.
- busy  out  4  remaining mult/div cycles; 0 = idle.

Behaviour:
- State registers:
  - ex_load_q (1 bit), ex_dst_q (5 bits): shadow of the ID/EX stage.
  - cnt (4 bits): drives `busy` directly.
- Reset (asynchronous, active-low; clock Clk):
  - Clear ex_load_q, ex_dst_q and cnt immediately.
  - As a result stall = 0, stallstall = 0 and busy = 0 while Reset = 0.
  - Reset asserted mid-operation aborts any countdown and removes any in-flight load bubble.
- stall (combinational, same cycle):
  - stall = ex_load_q & (ex_dst_q != 0) & ((id_use_rs & id_rs == ex_dst_q) | (id_use_rt & id_rt == ex_dst_q)).
- stallstall (combinational, same cycle):
  - stallstall = id_md_use & (cnt != 0).
- advance = ~stall & ~stallstall.
- Shadow update at each edge:
  - If advance: ex_load_q <= id_is_load; ex_dst_q <= id_dst.
  - Otherwise a bubble is inserted: ex_load_q <= 0; ex_dst_q <= 0.
  - Consequence: a load-use stall lasts exactly 1 cycle.
- Counter update at each edge, priority in this order:
  1. advance & id_md_start: cnt <= (id_md_is_div ? DIV_CYCLES : MULT_CYCLES).
  2. Else if cnt != 0: cnt <= cnt - 1.
  3. Else cnt holds at 0; no wrap below 0.
- Counter boundary rules:
  - A start can only advance when cnt == 0, because a start instruction also has id_md_use = 1. A reload over a nonzero count therefore cannot occur.
  - The counter keeps decrementing during load-use stalls.
- Simultaneous events:
  - stall and stallstall may both be 1; both are reported and the PC freezes on either.
  - A start that is blocked by a load-use stall does not load cnt; it loads on the first edge where advance = 1.
- Latency:
  - After a mult advances at edge T, cnt = MULT_CYCLES after T and reaches 0 after edge T + MULT_CYCLES.
  - A following mfhi in ID is held while cnt != 0 and advances on the first edge where cnt == 0.
- Register 0:
  - id_dst = 0 or a shadow destination of 0 never causes a stall.
  - A load to $0 never stalls.

Test Plan:
- Reset release with all inputs 0 → stall = 0, stallstall = 0, busy = 0. Assert Reset low while busy = 7 → busy = 0 immediately, without waiting for a clock edge.
- Load-use hazard:
  - Stimulus: cycle 0 ID = lw $8 (id_is_load = 1, id_dst = 8); cycle 1 ID = add reading rs = 8.
  - Response: stall = 1 in cycle 1 only, stall = 0 in cycle 2; ex_load_q = 0 after the bubble.
  - Repeat with rt = 8 and id_use_rt = 1 → same result. Repeat with id_use_rs = 0 → no stall.
- Load to $0:
  - Stimulus: lw $0 followed by a reader of rs = 0.
  - Response: stall stays 0.
- Mult then mfhi, with MULT_CYCLES = 5:
  - Stimulus: mult advances at edge T; mfhi is in ID from the next cycle.
  - Response: busy reads 5, 4, 3, 2, 1, 0 over the following cycles; stallstall = 1 for exactly 5 cycles; mfhi advances when busy = 0.
- Div with DIV_CYCLES = 10, followed by independent ALU ops (id_md_use = 0):
  - Response: busy counts 10 down to 0 and stallstall stays 0 throughout.
  - Then a mult in ID while busy = 3 → stallstall = 1 until busy = 0; cnt then loads 5.
- Combined hazards:
  - Stimulus: lw $9 is in EX while the ID instruction reads $9 and is also a mult.
  - Response: stall = 1 and cnt does not load; on the next cycle stall = 0 and the mult advances, so busy = 5 after that edge.
